// File: rtl/comparator_magnitude_serial_if.sv
// Bus bundle for comparator_magnitude_serial.
// Handshake: start is a request that is taken only while busy = 0; the edge
// that takes it also latches A and B. busy stays high for the whole
// comparison. done is a single-cycle pulse, with busy = 0, that marks fresh
// result flags. The flags then hold until the next done. There is no
// back-pressure and no queuing: a start raised while busy = 1 is dropped.
interface comparator_magnitude_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             A_greater_than_B;
  logic             A_equal_B;
  logic             A_less_than_B;
  logic             dbg_state;   // 0 = IDLE, 1 = COMPARE

  modport master (
    output start, A, B,
    input  busy, done, A_greater_than_B, A_equal_B, A_less_than_B, dbg_state
  );

  modport slave (
    input  start, A, B,
    output busy, done, A_greater_than_B, A_equal_B, A_less_than_B, dbg_state
  );
endinterface

// File: rtl/comparator_magnitude_serial.sv
// Serial MSB-first magnitude comparator, DIGIT bits per clock.
// Optional build macro: SIGNED_COMPARE_EN selects two's-complement ordering.
// When it is defined, the operand MSB is flipped at latch time so that the
// unsigned digit compare yields the signed order. When it is undefined, the
// ordering is unsigned.
module comparator_magnitude_serial #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  comparator_magnitude_serial_if.slave    bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0]    LAST_CNT = CW'(STEPS);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
`ifdef SIGNED_COMPARE_EN
  localparam logic [WIDTH-1:0] OP_MASK  = ONE << (WIDTH - 1);
`else
  localparam logic [WIDTH-1:0] OP_MASK  = ONE & '0;
`endif
  localparam bit EARLY = (EARLY_EXIT != 0);

  typedef enum logic {IDLE = 1'b0, COMPARE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt_q;
  logic             dec_q, dec_gt_q;
  logic             done_q, gt_q, eq_q, lt_q;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [CW-1:0]    cnt_inc;
  logic             differ, dig_gt, last_step, finish;
  logic             res_gt, res_eq, res_lt;

  // Digit compare, finish condition and the result the finishing edge will latch.
  always_comb begin
    a_dig     = a_sr[WIDTH-1 -: DIGIT];
    b_dig     = b_sr[WIDTH-1 -: DIGIT];
    differ    = (a_dig != b_dig);
    dig_gt    = (a_dig > b_dig);
    cnt_inc   = cnt_q + 1'b1;
    last_step = (cnt_inc == LAST_CNT);
    finish    = (state_q == COMPARE) && ((EARLY && differ) || last_step);
    // An earlier sticky decision wins over the current digit.
    res_gt    = dec_q ? dec_gt_q  : (differ &  dig_gt);
    res_lt    = dec_q ? !dec_gt_q : (differ & !dig_gt);
    res_eq    = !dec_q && !differ;
  end

  // Next-state logic: accept only from IDLE, and leave COMPARE on finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = COMPARE;
      COMPARE: if (finish)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath: latch operands, shift by one digit, track the sticky decision, publish the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      cnt_q    <= '0;
      dec_q    <= 1'b0;
      dec_gt_q <= 1'b0;
      done_q   <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.A ^ OP_MASK;
            b_sr     <= bus.B ^ OP_MASK;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            dec_gt_q <= 1'b0;
          end
        end
        COMPARE: begin
          a_sr  <= a_sr << DIGIT;
          b_sr  <= b_sr << DIGIT;
          cnt_q <= cnt_inc;
          if (differ && !dec_q) begin
            dec_q    <= 1'b1;
            dec_gt_q <= dig_gt;
          end
          if (finish) begin
            done_q <= 1'b1;
            gt_q   <= res_gt;
            eq_q   <= res_eq;
            lt_q   <= res_lt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy             = (state_q == COMPARE);
  assign bus.done             = done_q;
  assign bus.A_greater_than_B = gt_q;
  assign bus.A_equal_B        = eq_q;
  assign bus.A_less_than_B    = lt_q;
  assign bus.dbg_state        = (state_q == COMPARE);

endmodule

// File: tb/tb_comparator_magnitude_serial.sv
// Bench for comparator_magnitude_serial. It uses two instances: a full-length
// run (DIGIT=1, EARLY_EXIT=0) and an early-exit run (DIGIT=2, EARLY_EXIT=1).
// Expected entries hold the latency (busy cycles) and the flags {gt,eq,lt}.
module tb_comparator_magnitude_serial;

`ifdef SIGNED_COMPARE_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic clk = 1'b0;
  logic rst_n;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q_full[$];
  logic [7:0] exp_q_early[$];

  comparator_magnitude_serial_if #(.WIDTH(8)) bus_full ();
  comparator_magnitude_serial_if #(.WIDTH(8)) bus_early ();

  comparator_magnitude_serial #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(0)) dut_full (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_full)
  );

  comparator_magnitude_serial #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) dut_early (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_early)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] ent(input int k, input logic [2:0] f);
    return {5'(k), f};
  endfunction

  function automatic logic [5:0] status(input int sel);
    if (sel == 0)
      return {bus_full.dbg_state, bus_full.busy, bus_full.done,
              bus_full.A_greater_than_B, bus_full.A_equal_B, bus_full.A_less_than_B};
    else
      return {bus_early.dbg_state, bus_early.busy, bus_early.done,
              bus_early.A_greater_than_B, bus_early.A_equal_B, bus_early.A_less_than_B};
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (sel == 0) begin
      bus_full.start = s; bus_full.A = a; bus_full.B = b;
    end else begin
      bus_early.start = s; bus_early.A = a; bus_early.B = b;
    end
  endtask

  // Raise start now, hold it for one edge, then scramble the operands.
  task automatic start_now(input int sel, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] e, input bit push);
    drive(sel, 1'b1, a, b);
    if (push) begin
      if (sel == 0) exp_q_full.push_back(e);
      else          exp_q_early.push_back(e);
    end
    @(negedge clk);
    drive(sel, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic issue(input int sel, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] e, input bit push);
    @(negedge clk);
    start_now(sel, a, b, e, push);
  endtask

  task automatic wait_idle(input int sel);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (status(sel)[4] == 1'b0) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL timeout_busy sel=%0d", sel);
  endtask

  task automatic run(input int sel, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] fu, input logic [2:0] fs, input int ku, input int ks);
    issue(sel, a, b, SGN ? ent(ks, fs) : ent(ku, fu), 1'b1);
    wait_idle(sel);
  endtask

  // ---------------- scoreboard monitors ----------------
  int         busy_cnt_full  = 0;
  int         busy_cnt_early = 0;
  logic [7:0] e_full, e_early;

  // Full-length instance: on every done, pop and compare the flags and busy length.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt_full = 0;
    end else begin
      if (bus_full.done) begin
        n_vec++;
        if (exp_q_full.size() == 0) begin
          n_err++;
          $display("FAIL full_unexpected_done flags=%b", status(0)[2:0]);
        end else begin
          e_full = exp_q_full.pop_front();
          if (status(0)[2:0] !== e_full[2:0] || busy_cnt_full != int'(e_full[7:3])) begin
            n_err++;
            $display("FAIL full_result flags=%b cycles=%0d expected flags=%b cycles=%0d",
                     status(0)[2:0], busy_cnt_full, e_full[2:0], e_full[7:3]);
          end
        end
        busy_cnt_full = 0;
      end
      if (bus_full.busy) busy_cnt_full++;
    end
  end

  // Early-exit instance: the same check against its own queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt_early = 0;
    end else begin
      if (bus_early.done) begin
        n_vec++;
        if (exp_q_early.size() == 0) begin
          n_err++;
          $display("FAIL early_unexpected_done flags=%b", status(1)[2:0]);
        end else begin
          e_early = exp_q_early.pop_front();
          if (status(1)[2:0] !== e_early[2:0] || busy_cnt_early != int'(e_early[7:3])) begin
            n_err++;
            $display("FAIL early_result flags=%b cycles=%0d expected flags=%b cycles=%0d",
                     status(1)[2:0], busy_cnt_early, e_early[2:0], e_early[7:3]);
          end
        end
        busy_cnt_early = 0;
      end
      if (bus_early.busy) busy_cnt_early++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(0, 1'b1, 8'h12, 8'h34);
    drive(1, 1'b1, 8'h56, 8'h78);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_full",  8'(status(0)), 8'h00);
    chk("reset_early", 8'(status(1)), 8'h00);
    drive(0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 8'(status(0)), 8'h00);

    // Full-length, DIGIT=1: always 8 busy cycles.
    run(0, 8'hA5, 8'hA4, GT, GT, 8, 8);
    run(0, 8'h3C, 8'h3C, EQ, EQ, 8, 8);
    run(0, 8'h80, 8'h7F, GT, LT, 8, 8);
    run(0, 8'hFF, 8'h01, GT, LT, 8, 8);
    run(0, 8'h80, 8'h80, EQ, EQ, 8, 8);

    // Early exit, DIGIT=2: stops at the first differing digit.
    run(1, 8'h40, 8'h80, LT, GT, 1, 1);
    run(1, 8'hFF, 8'hFE, GT, GT, 4, 4);
    run(1, 8'h30, 8'h20, GT, GT, 2, 2);
    run(1, 8'h3C, 8'h3D, LT, LT, 4, 4);
    run(1, 8'h80, 8'h7F, GT, LT, 1, 1);
    run(1, 8'h3C, 8'h3C, EQ, EQ, 4, 4);
    run(1, 8'h01, 8'h02, LT, LT, 4, 4);

    // A start pulsed mid-compare must be dropped.
    issue(0, 8'h00, 8'hFF, SGN ? ent(8, GT) : ent(8, LT), 1'b1);
    repeat (3) @(negedge clk);
    drive(0, 1'b1, 8'hFF, 8'h00);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00);
    wait_idle(0);

    // Back-to-back: start held high in the done cycle is taken at once.
    issue(0, 8'h12, 8'h34, ent(8, LT), 1'b1);
    wait_idle(0);
    start_now(0, 8'h55, 8'h55, ent(8, EQ), 1'b1);
    chk("b2b_no_idle_busy", {7'd0, status(0)[4]}, 8'h01);
    wait_idle(0);

    // Reset asserted at E2: abort, no done, flags cleared.
    issue(0, 8'h0F, 8'h0E, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_full_cleared",  8'(status(0)), 8'h00);
    chk("abort_early_cleared", 8'(status(1)), 8'h00);
    repeat (10) @(negedge clk);
    chk("abort_still_quiet", 8'(status(0)), 8'h00);
    run(0, 8'h0F, 8'h0E, GT, GT, 8, 8);

    repeat (3) @(negedge clk);
    chk("full_queue_drained",  8'(exp_q_full.size()),  8'h00);
    chk("early_queue_drained", 8'(exp_q_early.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/comparator_magnitude_serial.md
# comparator_magnitude_serial

Parametrised, sequential magnitude comparator for the comparator family. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and can stop early once the first differing digit is found. It produces registered greater-than, equal and less-than flags under a start/busy/done handshake. Operands may be unsigned, or two's-complement when compiled for it. It sits wherever wide operands must be ordered without a full-width combinational comparator in one cycle.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ 1.
- DIGIT, 1, bits compared per cycle; must be ≥ 1 and divide WIDTH exactly.
- EARLY_EXIT, 1, 1 = finish on the first differing digit; 0 = always run all digits.
- Derived: STEPS = WIDTH/DIGIT; step counter width $clog2(STEPS+1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only while busy = 0.
- A  input  WIDTH  operand A; sampled on the accepting edge only.
- B  input  WIDTH  operand B; sampled on the accepting edge only.
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse; result flags valid and updated.
- A_greater_than_B  output  1  result flag, held until the next done.
- A_equal_B  output  1  result flag, held until the next done.
- A_less_than_B  output  1  result flag, held until the next done.

## Operation
- Reset (rst_n = 0 at an edge): state IDLE, busy = 0, done = 0, all three flags = 0, counter = 0.
- States:
  - IDLE: busy = 0.
    - start = 1 at an edge latches A and B into shift registers, clears the counter, and moves to COMPARE.
  - COMPARE: busy = 1.
    - Each edge compares the top DIGIT bits of both registers, shifts both left by DIGIT, and increments the counter.
    - Digits differ and EARLY_EXIT = 1: set GT or LT from that digit, pulse done, go to IDLE.
    - Counter reaches STEPS: set the flag from the first differing digit seen, or EQ if none; pulse done; go to IDLE.
    - EARLY_EXIT = 0: the first differing digit is recorded in a sticky decided bit, and later digits are ignored.
- Exactly one flag is 1 after any done; all flags are 0 only between reset and the first done.
- start while busy = 1 is ignored; there is no queuing.
- Operand inputs are don't-care except on the accepting edge.
- rst_n = 0 during COMPARE aborts the comparison: no done pulse, flags cleared.

## Timing
- Call the accepting edge E0. The last compare edge is Ek, where:
  - k = index (1-based) of the first differing digit, when EARLY_EXIT = 1;
  - k = STEPS, when EARLY_EXIT = 0 or the operands are equal.
- busy = 1 from after E0 until Ek; done = 1 for exactly the cycle after Ek.
- Flags change only at Ek.
- The FSM is in IDLE during the done cycle, so a start in that cycle is accepted. Back-to-back throughput is one comparison per k+1 edges.
- The done cycle is the only cycle where done = 1 and busy = 0 together with fresh flags.
- There are no combinational paths from inputs to outputs.

## Configuration
- Macro SIGNED_COMPARE_EN.
- Defined: operands are two's-complement. The operand MSB is inverted in both latched registers at E0, so the ordering is signed. Example: A = 8'h80, B = 8'h7F gives LT.
- Undefined: unsigned ordering. The same example gives GT.
- Latency, handshake and EQ behaviour are identical in both builds.

## Test plan
- Reset: hold rst_n = 0 for 2 edges with start = 1 → busy = 0, done = 0, all flags 0, no acceptance.
- Full-length unsigned (WIDTH=8, DIGIT=1, EARLY_EXIT=0), A = 8'hA5, B = 8'hA4 → done in the cycle after E8, GT = 1; A = B = 8'h3C → EQ = 1 after E8.
- Early exit (EARLY_EXIT=1, DIGIT=2), A = 8'h40, B = 8'h80 → digit 0 differs, done after E1, LT = 1; A = 8'hFF, B = 8'hFE → done after E4, GT = 1.
- Handshake:
  - start pulsed mid-COMPARE with new operands → ignored, first result unchanged.
  - start held high in the done cycle → new comparison accepted with no idle cycle.
- Reset mid-operation: rst_n = 0 at E2 of an 8-step run → no done, flags 0, IDLE; next start completes normally.
- Signed build (SIGNED_COMPARE_EN defined): A = 8'hFF (-1), B = 8'h01 → LT; A = 8'h80, B = 8'h80 → EQ; compare each result against the unsigned build.
